mem_tile_resp: RTL and testbench

// - Responder (slave) end of the memOpm/memOK tile-memory bus driven by the L1 caches and the MMIO path.
// - Backs a local 128-bit tile SRAM and serves four request types:
//   - tile read/write (UMEM_OPM_RD_TILE / UMEM_OPM_WR_TILE);
//   - scalar load/store (opm[4:3]=01 load, 10 store).
// - Signals progress with the READY/HOLD/OK handshake.
// - Sits between the cache/MMIO initiators and the SoC memory; also stands in as the bench/sim main memory.

---
 rtl/mem_tile_resp_if.sv | 19 +
 rtl/mem_tile_resp.sv | 180 ++++++++++++++++++
 tb/tb_mem_tile_resp.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_tile_resp_if.sv
// memOpm/memOK tile-memory bus: the initiator drives the request, the responder
// answers with READY/HOLD/OK and read data.
interface mem_tile_resp_if;
   logic [31:0]  memAddr;
   logic [4:0]   memOpm;
   logic [127:0] memDataIn;
   logic [127:0] memDataOut;
   logic [1:0]   memOK;

   modport master (
      output memAddr, memOpm, memDataIn,
      input  memDataOut, memOK
   );

   modport slave (
      input  memAddr, memOpm, memDataIn,
      output memDataOut, memOK
   );
endinterface

// File: rtl/mem_tile_resp.sv
// Responder end of the memOpm/memOK bus backed by a local 128-bit tile SRAM.
// Define MEM_TILE_RESP_FAULT_EN to answer out-of-range addresses with FAULT.
module mem_tile_resp #(
   parameter int unsigned ADDR_BITS = 12,
   parameter int unsigned LAT       = 3
) (
   input  logic            clock,
   input  logic            reset,
   mem_tile_resp_if.slave  mem
);

   localparam logic [4:0] OPM_READY = 5'b00000;
   localparam logic [1:0] OK_READY  = 2'b00;
   localparam logic [1:0] OK_HOLD   = 2'b01;
   localparam logic [1:0] OK_OK     = 2'b10;
   localparam logic [1:0] OK_FAULT  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [31:0]    addr_q, addr_d;
   logic [4:0]     opm_q, opm_d;
   logic [127:0]   wdata_q, wdata_d;
   logic [127:0]   dout_q, dout_d;
   logic           fault_q, fault_d;

   logic [127:0]   sram [0:(2**ADDR_BITS)-1];

   logic [31:0]          acc_addr;
   logic [4:0]           acc_opm;
   logic [127:0]         acc_wdata;
   logic [ADDR_BITS-1:0] acc_idx;
   logic [3:0]           acc_b;
   logic [3:0]           nbytes;
   logic [127:0]         tile;
   logic [127:0]         wr_tile;
   logic [127:0]         rd_data;
   logic [63:0]          ld_raw;
   logic                 wr_need;
   logic                 addr_fault;
   logic                 sram_we;
   logic                 sgn;

   // With LAT==1 the access happens on the accept edge, straight from the bus.
   assign acc_addr  = (state_q == S_IDLE) ? mem.memAddr   : addr_q;
   assign acc_opm   = (state_q == S_IDLE) ? mem.memOpm    : opm_q;
   assign acc_wdata = (state_q == S_IDLE) ? mem.memDataIn : wdata_q;
   assign acc_idx   = acc_addr[ADDR_BITS+3:4];
   assign acc_b     = acc_addr[3:0];
   assign nbytes    = 4'd1 << acc_opm[1:0];
   assign tile      = sram[acc_idx];
   assign sgn       = ~acc_opm[2];

`ifdef MEM_TILE_RESP_FAULT_EN
   assign addr_fault = |acc_addr[31:ADDR_BITS+4];
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^acc_addr[31:ADDR_BITS+4];
   assign addr_fault     = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      wr_tile = tile;
      wr_need = 1'b0;
      ld_raw  = '0;
      case (acc_opm[4:3])
         2'b01: begin
            // Byte lanes wrap modulo 16 inside the tile.
            for (int unsigned i = 0; i < 8; i++)
               if (4'(i) < nbytes)
                  ld_raw[8*i +: 8] = tile[{acc_b + 4'(i), 3'b000} +: 8];
            case (acc_opm[1:0])
               2'd0:    rd_data[63:0] = {{56{sgn & ld_raw[7]}},  ld_raw[7:0]};
               2'd1:    rd_data[63:0] = {{48{sgn & ld_raw[15]}}, ld_raw[15:0]};
               2'd2:    rd_data[63:0] = {{32{sgn & ld_raw[31]}}, ld_raw[31:0]};
               default: rd_data[63:0] = ld_raw;
            endcase
         end
         2'b10: begin
            for (int unsigned i = 0; i < 8; i++)
               if (4'(i) < nbytes)
                  wr_tile[{acc_b + 4'(i), 3'b000} +: 8] = acc_wdata[8*i +: 8];
            wr_need = 1'b1;
         end
         2'b11: begin
            if (acc_opm[0]) begin
               wr_tile = acc_wdata;
               wr_need = 1'b1;
            end else begin
               rd_data = tile;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      opm_d   = opm_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      fault_d = fault_q;
      sram_we = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem.memOpm != OPM_READY) begin
               addr_d  = mem.memAddr;
               opm_d   = mem.memOpm;
               wdata_d = mem.memDataIn;
               cnt_d   = 4'(LAT);
               if (LAT == 1) begin
                  fault_d = addr_fault;
                  dout_d  = addr_fault ? '0 : rd_data;
                  sram_we = wr_need & ~addr_fault;
                  state_d = S_DONE;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (mem.memOpm == OPM_READY) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_d == 4'd1) begin
                  fault_d = addr_fault;
                  dout_d  = addr_fault ? '0 : rd_data;
                  sram_we = wr_need & ~addr_fault;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (mem.memOpm == OPM_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         opm_q   <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         opm_q   <= opm_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         fault_q <= fault_d;
      end
   end

   always_ff @(posedge clock) begin
      if (sram_we) sram[acc_idx] <= wr_tile;
   end

   always_comb begin
      mem.memOK = OK_READY;
      case (state_q)
         S_BUSY:  mem.memOK = OK_HOLD;
         S_DONE:  mem.memOK = fault_q ? OK_FAULT : OK_OK;
         default: mem.memOK = OK_READY;
      endcase
   end

   assign mem.memDataOut = dout_q;

endmodule

// File: tb/tb_mem_tile_resp.sv
// Bench for mem_tile_resp: vector table through a scoreboard, plus abort,
// held-DONE, latched-field and async-reset sequences.
module tb_mem_tile_resp;

   localparam int unsigned LAT = 3;

   localparam logic [4:0] READY  = 5'b00000;
   localparam logic [4:0] RD     = 5'b11000;
   localparam logic [4:0] WR     = 5'b11001;
   localparam logic [1:0] K_RDY  = 2'b00;
   localparam logic [1:0] K_HOLD = 2'b01;
   localparam logic [1:0] K_OK   = 2'b10;
   localparam logic [1:0] K_FLT  = 2'b11;

   localparam logic [127:0] P    = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
   localparam logic [127:0] P_AA = 128'hAA0E0D0C_0B0A0908_07060504_03020100;
   localparam logic [127:0] T230 = 128'h87654321_0B0A0908_07060504_03020100;
   localparam logic [127:0] T10  = 128'h55667788_0B0A0908_07060504_11223344;
   localparam logic [127:0] X1   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [127:0] D1   = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

   typedef struct {
      logic [31:0]  addr;
      logic [4:0]   opm;
      logic [127:0] din;
      logic [127:0] exp_data;
      logic [1:0]   exp_ok;
      string        name;
   } vec_t;

   typedef struct {
      logic [127:0] data;
      logic [1:0]   ok;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];
   vec_t vecs[16];

   mem_tile_resp_if bus();

   mem_tile_resp #(.ADDR_BITS(12), .LAT(LAT)) dut (
      .clock (clk),
      .reset (rst),
      .mem   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [4:0] op, input logic [127:0] d);
      @(negedge clk);
      bus.memAddr   = a;
      bus.memOpm    = op;
      bus.memDataIn = d;
   endtask

   task automatic wait_done(input string name, output int holds);
      bit   done;
      exp_t e;
      holds = 0;
      done  = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.memOK == K_OK || bus.memOK == K_FLT) begin
            done = 1'b1;
            break;
         end
         if (bus.memOK == K_HOLD) holds++;
      end
      chk({name, "_done"}, 128'(done), 128'd1);
      if (done) begin
         chk({name, "_sb"}, 128'(sb.size() != 0), 128'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({name, "_ok"}, 128'(bus.memOK), 128'(e.ok));
            chk({name, "_data"}, bus.memDataOut, e.data);
         end
      end
   endtask

   task automatic release_req(input string name);
      bus.memOpm = READY;
      @(negedge clk);
      chk({name, "_ready"}, 128'(bus.memOK), 128'(K_RDY));
   endtask

   task automatic req(input logic [31:0] a, input logic [4:0] op, input logic [127:0] d,
                      input logic [127:0] ed, input logic [1:0] eo, input string name);
      int   holds;
      exp_t e;
      drive(a, op, d);
      e.data = ed;
      e.ok   = eo;
      sb.push_back(e);
      wait_done(name, holds);
      chk({name, "_hold"}, 128'(holds), 128'(LAT - 1));
      release_req(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   holds;
      exp_t e;
      checks = 0;
      errors = 0;

      vecs[0]  = '{32'h0000_0120, WR,       P,                     '0,                       K_OK, "wr_tile"};
      vecs[1]  = '{32'h0000_0120, RD,       '0,                    P,                        K_OK, "rd_tile"};
      vecs[2]  = '{32'h0000_012F, 5'b10000, 128'hAA,               '0,                       K_OK, "st_b15"};
      vecs[3]  = '{32'h0000_0120, RD,       '0,                    P_AA,                     K_OK, "rd_after_stb"};
      vecs[4]  = '{32'h0000_012F, 5'b01000, '0,                    128'hFFFF_FFFF_FFFF_FFAA, K_OK, "ld_sb"};
      vecs[5]  = '{32'h0000_012F, 5'b01100, '0,                    128'hAA,                  K_OK, "ld_zb"};
      vecs[6]  = '{32'h0000_0230, WR,       P,                     '0,                       K_OK, "wr_230"};
      vecs[7]  = '{32'h0000_023E, 5'b01011, '0,                    128'h0504_0302_0100_0F0E, K_OK, "ld8_wrap"};
      vecs[8]  = '{32'h0000_023C, 5'b10010, 128'h8765_4321,        '0,                       K_OK, "st4"};
      vecs[9]  = '{32'h0000_023C, 5'b01010, '0,                    128'hFFFF_FFFF_8765_4321, K_OK, "ld_sw"};
      vecs[10] = '{32'h0000_023E, 5'b01101, '0,                    128'h8765,                K_OK, "ld_zh"};
      vecs[11] = '{32'h0000_0230, RD,       '0,                    T230,                     K_OK, "rd_230"};
      vecs[12] = '{32'h0000_012C, 5'b10011, 128'h1122334455667788, '0,                       K_OK, "st8_wrap"};
      vecs[13] = '{32'h0000_0120, RD,       '0,                    T10,                      K_OK, "rd_after_st8"};
      vecs[14] = '{32'h0000_0122, 5'b01001, '0,                    128'h1122,                K_OK, "ld_sh"};
`ifdef MEM_TILE_RESP_FAULT_EN
      vecs[15] = '{32'h0001_0120, RD,       '0,                    '0,                       K_FLT, "rd_oor"};
`else
      vecs[15] = '{32'h0001_0120, RD,       '0,                    T10,                      K_OK, "rd_wrap_idx"};
`endif

      rst           = 1'b1;
      bus.memAddr   = '0;
      bus.memOpm    = READY;
      bus.memDataIn = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("idle_ok", 128'(bus.memOK), 128'(K_RDY));
         chk("idle_data", bus.memDataOut, '0);
      end

      for (int i = 0; i < 16; i++)
         req(vecs[i].addr, vecs[i].opm, vecs[i].din, vecs[i].exp_data, vecs[i].exp_ok, vecs[i].name);

      // Abort in the second BUSY cycle: no write happens.
      drive(32'h0000_0120, WR, '1);
      @(negedge clk);
      chk("abort_hold1", 128'(bus.memOK), 128'(K_HOLD));
      @(negedge clk);
      chk("abort_hold2", 128'(bus.memOK), 128'(K_HOLD));
      bus.memOpm = READY;
      @(negedge clk);
      chk("abort_ready", 128'(bus.memOK), 128'(K_RDY));
      req(32'h0000_0120, RD, '0, T10, K_OK, "rd_after_abort");

      // Held in DONE with changed bus: OK persists, single write with latched data.
      drive(32'h0000_0340, WR, X1);
      e.data = '0;
      e.ok   = K_OK;
      sb.push_back(e);
      wait_done("held", holds);
      bus.memDataIn = ~X1;
      bus.memOpm    = RD;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("held_ok", 128'(bus.memOK), 128'(K_OK));
         chk("held_data", bus.memDataOut, '0);
      end
      release_req("held");
      req(32'h0000_0340, RD, '0, X1, K_OK, "rd_after_held");

      // Request fields change after accept; the latched copy is used.
      drive(32'h0000_0450, WR, D1);
      e.data = '0;
      e.ok   = K_OK;
      sb.push_back(e);
      @(negedge clk);
      bus.memAddr   = 32'h0000_0460;
      bus.memDataIn = ~D1;
      wait_done("latched", holds);
      chk("latched_hold", 128'(holds + 1), 128'(LAT - 1));
      release_req("latched");
      req(32'h0000_0450, RD, '0, D1, K_OK, "rd_latched");

      // Asynchronous reset mid-BUSY.
      drive(32'h0000_0120, WR, '1);
      @(negedge clk);
      chk("rst_hold", 128'(bus.memOK), 128'(K_HOLD));
      #2 rst = 1'b1;
      #1 chk("rst_async_ok", 128'(bus.memOK), 128'(K_RDY));
      chk("rst_async_data", bus.memDataOut, '0);
      @(negedge clk);
      rst        = 1'b0;
      bus.memOpm = READY;
      @(negedge clk);
      req(32'h0000_0120, RD, '0, T10, K_OK, "rd_after_rst");

`ifdef MEM_TILE_RESP_FAULT_EN
      req(32'h8000_0000, RD, '0, '0, K_FLT, "fault_8000");
`endif

      chk("sb_empty", 128'(sb.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
